matrix_port_arbiter: RTL
========================

// Module: matrix_port_arbiter
// PURPOSE
//  Shares the single read/write port set of one `matrix` instance between NUM_CLIENTS requesters
//  (initialiser, matrix_divider, later pipeline stages), replacing the ad-hoc `initializing` mux.
//  Round-robin, ownership-based grant: the owner holds the port for a whole transaction burst.
//  Tracks outstanding reads, so ownership never changes while a row/col read is in flight.
// PARAMETERS
//  NUM_CLIENTS  2   number of requesters (>=2)
//  NUM_ROWS     11  matrix rows; RAW = $clog2(NUM_ROWS)
//  NUM_COLS     4   matrix cols; CAW = $clog2(NUM_COLS)
//  SCALAR_BITS  32  element width W
// PORTS (N = NUM_CLIENTS; cl_* buses packed, client i at [i*w +: w])
//  clk                 in   1      clock, rising edge
//  rst                 in   1      asynchronous, active-high reset
//  cl_req              in   N      level request; held high for the whole burst
//  cl_grant            out  N      registered one-hot ownership (or all-zero)
//  cl_row_addr         in   N*RAW  row read address
//  cl_row_addr_ready   in   N      row read strobe
//  cl_col_addr         in   N*CAW  col read address
//  cl_col_addr_ready   in   N      col read strobe
//  cl_write_row_addr   in   N*RAW  write row
//  cl_write_col_addr   in   N*CAW  write col
//  cl_write_data       in   N*W    write element
//  cl_write_ready      in   N      write strobe
//  cl_row_valid        out  N      mat_row_valid routed to recorded owner only
//  cl_col_valid        out  N      mat_col_valid routed to recorded owner only
//  mat_row_addr        out  RAW    to matrix
//  mat_row_addr_ready  out  1      to matrix
//  mat_row_valid       in   1      from matrix
//  mat_col_addr        out  CAW    to matrix
//  mat_col_addr_ready  out  1      to matrix
//  mat_col_valid       in   1      from matrix
//  mat_write_row_addr  out  RAW    to matrix
//  mat_write_col_addr  out  CAW    to matrix
//  mat_write_data      out  W      to matrix
//  mat_write_ready     out  1      to matrix
//  (row_out/col_out data buses go matrix->clients directly, not through this block.)
// BEHAVIOUR
//  Reset: cl_grant=0, owner=0, rr_ptr=0, row_pend=col_pend=0, state=IDLE; all mat_*_ready=0,
//   cl_*_valid=0. Addr/data outputs are don't-care while the matching ready is 0 (drive the owner mux).
//  FSM IDLE -> GRANT -> [DRAIN] -> IDLE:
//   IDLE: if |cl_req, winner = first requester at or after rr_ptr (wrapping mod N); owner<=winner,
//    cl_grant<=onehot(winner), ->GRANT. Grant latency = 1 cycle after req is sampled.
//   GRANT: owner's strobes/addr/data are forwarded combinationally (0 added latency).
//    If owner req falls: rr_ptr<=owner+1 (wrap to 0 at N); cl_grant<=0;
//     ->IDLE if no read pending at that edge, else ->DRAIN.
//   DRAIN: all mat_*_ready forced 0; ->IDLE once row_pend and col_pend are both clear.
//  Ownership handover therefore includes at least one IDLE cycle with cl_grant==0.
//  Pending flags: row_pend set by a forwarded row strobe, cleared by mat_row_valid; if strobe and
//   valid occur in the same cycle, the flag stays set. col_pend is identical for the col port.
//   Owners must not issue a new read on a port while its flag is set.
//  cl_row_valid/cl_col_valid = mat_*_valid & onehot(owner) in GRANT and DRAIN; 0 in IDLE.
//  Strobes from non-owners (and from the owner in IDLE/DRAIN) are dropped, never queued.
//  Owner req falling in the same cycle as its final strobe: the strobe is forwarded.
//  A req pulse shorter than the grant latency still receives an empty one-cycle grant.
// STRUCTURE
//  Shared package: typedef enum {IDLE, GRANT, DRAIN} arb_state_t; client-index width $clog2(N).
//  Sub-module rr_picker (combinational: req vector + rr_ptr -> winner index, any_req).
// TESTING (2 clients, matrix model with read latency 2)
//  Reset asserted mid-DRAIN -> cl_grant=0 and mat_*_ready=0 asynchronously; IDLE after release.
//  req=01, client0 writes (3,2)=0x3F800000 -> grant=01 one cycle later; write seen same cycle; reads back.
//  req=11 after reset -> client0 first; req0 drops -> one cycle grant=00, then grant=10; req=11 again -> client0.
//  Owner row read of row 5, req dropped next cycle -> DRAIN held until valid; cl_row_valid=01 only; then IDLE.
//  Client1 write_ready while client0 owns -> mat_write_ready follows client0 only; target element unchanged.

Source files
------------

// File: rtl/matrix_port_arbiter_pkg.sv
// Shared types for the matrix port arbiter: FSM state encoding and index-width helper.
package matrix_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_port_arbiter_if.sv
// Client-side and matrix-side port bundle of the arbiter; master is the arbiter's view.
interface matrix_port_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int NUM_ROWS    = 11,
  parameter int NUM_COLS    = 4,
  parameter int SCALAR_BITS = 32
);
  localparam int N   = NUM_CLIENTS;
  localparam int RAW = $clog2(NUM_ROWS);
  localparam int CAW = $clog2(NUM_COLS);
  localparam int W   = SCALAR_BITS;

  // *_ready are one-cycle strobes taken without back-pressure when forwarded;
  // *_valid marks the single cycle in which the matrix presents read data.
  logic [N-1:0]     cl_req;
  logic [N-1:0]     cl_grant;
  logic [N*RAW-1:0] cl_row_addr;
  logic [N-1:0]     cl_row_addr_ready;
  logic [N*CAW-1:0] cl_col_addr;
  logic [N-1:0]     cl_col_addr_ready;
  logic [N*RAW-1:0] cl_write_row_addr;
  logic [N*CAW-1:0] cl_write_col_addr;
  logic [N*W-1:0]   cl_write_data;
  logic [N-1:0]     cl_write_ready;
  logic [N-1:0]     cl_row_valid;
  logic [N-1:0]     cl_col_valid;

  logic [RAW-1:0]   mat_row_addr;
  logic             mat_row_addr_ready;
  logic             mat_row_valid;
  logic [CAW-1:0]   mat_col_addr;
  logic             mat_col_addr_ready;
  logic             mat_col_valid;
  logic [RAW-1:0]   mat_write_row_addr;
  logic [CAW-1:0]   mat_write_col_addr;
  logic [W-1:0]     mat_write_data;
  logic             mat_write_ready;

  modport master (
    input  cl_req, cl_row_addr, cl_row_addr_ready, cl_col_addr, cl_col_addr_ready,
    input  cl_write_row_addr, cl_write_col_addr, cl_write_data, cl_write_ready,
    output cl_grant, cl_row_valid, cl_col_valid,
    output mat_row_addr, mat_row_addr_ready, mat_col_addr, mat_col_addr_ready,
    output mat_write_row_addr, mat_write_col_addr, mat_write_data, mat_write_ready,
    input  mat_row_valid, mat_col_valid
  );

  modport slave (
    output cl_req, cl_row_addr, cl_row_addr_ready, cl_col_addr, cl_col_addr_ready,
    output cl_write_row_addr, cl_write_col_addr, cl_write_data, cl_write_ready,
    input  cl_grant, cl_row_valid, cl_col_valid,
    input  mat_row_addr, mat_row_addr_ready, mat_col_addr, mat_col_addr_ready,
    input  mat_write_row_addr, mat_write_col_addr, mat_write_data, mat_write_ready,
    output mat_row_valid, mat_col_valid
  );

endinterface

// File: rtl/matrix_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo N.
module matrix_port_arbiter_rr_picker
  import matrix_port_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          any_req_o
);

  logic [IW-1:0] cand;

  // Scan farthest-first so the candidate closest to ptr_i overwrites the others.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        winner_o  = cand;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_port_arbiter.sv
// Ownership-based round-robin arbiter sharing one matrix read/write port set between clients.
module matrix_port_arbiter
  import matrix_port_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int NUM_ROWS    = 11,
  parameter int NUM_COLS    = 4,
  parameter int SCALAR_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_port_arbiter_if.master bus,
  output arb_state_t            dbg_state_o
);

  localparam int N   = NUM_CLIENTS;
  localparam int RAW = $clog2(NUM_ROWS);
  localparam int CAW = $clog2(NUM_COLS);
  localparam int W   = SCALAR_BITS;
  localparam int IW  = idx_w(N);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          row_pend_q, row_pend_d;
  logic          col_pend_q, col_pend_d;

  logic [IW-1:0] winner;
  logic          any_req;
  logic [N-1:0]  owner_oh;
  logic          owner_req, own_row_stb, own_col_stb, own_wr_stb;
  logic [RAW-1:0] row_addr, wr_row_addr;
  logic [CAW-1:0] col_addr, wr_col_addr;
  logic [W-1:0]   wr_data;
  logic           fwd;

  matrix_port_arbiter_rr_picker #(.N(N)) u_picker (
    .req_i     (bus.cl_req),
    .ptr_i     (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Owner mux: addresses/data always follow the recorded owner, strobes are gated below.
  always_comb begin
    owner_oh    = '0;
    owner_req   = 1'b0;
    own_row_stb = 1'b0;
    own_col_stb = 1'b0;
    own_wr_stb  = 1'b0;
    row_addr    = '0;
    col_addr    = '0;
    wr_row_addr = '0;
    wr_col_addr = '0;
    wr_data     = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IW'(i)) begin
        owner_oh[i] = 1'b1;
        owner_req   = bus.cl_req[i];
        own_row_stb = bus.cl_row_addr_ready[i];
        own_col_stb = bus.cl_col_addr_ready[i];
        own_wr_stb  = bus.cl_write_ready[i];
        row_addr    = bus.cl_row_addr[i*RAW +: RAW];
        col_addr    = bus.cl_col_addr[i*CAW +: CAW];
        wr_row_addr = bus.cl_write_row_addr[i*RAW +: RAW];
        wr_col_addr = bus.cl_write_col_addr[i*CAW +: CAW];
        wr_data     = bus.cl_write_data[i*W +: W];
      end
    end
  end

  assign fwd = (state_q == GRANT);

  assign bus.mat_row_addr       = row_addr;
  assign bus.mat_col_addr       = col_addr;
  assign bus.mat_write_row_addr = wr_row_addr;
  assign bus.mat_write_col_addr = wr_col_addr;
  assign bus.mat_write_data     = wr_data;
  assign bus.mat_row_addr_ready = fwd & own_row_stb;
  assign bus.mat_col_addr_ready = fwd & own_col_stb;
  assign bus.mat_write_ready    = fwd & own_wr_stb;

  assign bus.cl_row_valid = (state_q != IDLE && bus.mat_row_valid) ? owner_oh : '0;
  assign bus.cl_col_valid = (state_q != IDLE && bus.mat_col_valid) ? owner_oh : '0;
  assign bus.cl_grant     = grant_q;
  assign dbg_state_o      = state_q;

  // A strobe in the same cycle as the returning valid belongs to a new read, so set wins.
  assign row_pend_d = bus.mat_row_addr_ready ? 1'b1 : (bus.mat_row_valid ? 1'b0 : row_pend_q);
  assign col_pend_d = bus.mat_col_addr_ready ? 1'b1 : (bus.mat_col_valid ? 1'b0 : col_pend_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          rr_ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
          grant_d  = '0;
          state_d  = (row_pend_d || col_pend_d) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!row_pend_q && !col_pend_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      row_pend_q <= 1'b0;
      col_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      row_pend_q <= row_pend_d;
      col_pend_q <= col_pend_d;
    end
  end

endmodule
